// File: rtl/uc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uc_arbiter
// Description : Round-robin unit-clause arbiter feeding a literal FIFO with
//               sticky conflict detection. Optional macro UC_DEDUP_EN drops
//               literals already buffered.
// Revision    : 1.0 - initial release
// ============================================================================
module uc_arbiter #(
  parameter int NUM_ENG = 4,
  parameter int LIT_W   = 8,
  parameter int DEPTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_ENG*LIT_W-1:0]   eng_lit,
  input  logic [NUM_ENG-1:0]         eng_valid,
  output logic [NUM_ENG-1:0]         eng_ready,
  output logic [LIT_W-1:0]           ucarb2gst_lit,
  output logic                       ucarb2gst_empty,
  input  logic                       gst2ucarb_pop,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       conflict,
  input  logic                       conflict_clr
);

  localparam int C_AW  = $clog2(DEPTH);
  localparam int C_CW  = $clog2(DEPTH+1);
  localparam int C_RRW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  logic [LIT_W-1:0] r_mem [DEPTH];
  logic [C_AW-1:0]  r_wptr;
  logic [C_AW-1:0]  r_rptr;
  logic [C_CW-1:0]  r_count;
  logic [C_RRW-1:0] r_rr;
  logic             r_conflict;

  logic [LIT_W-1:0] w_eng_lit [NUM_ENG];
  logic [C_RRW-1:0] w_order   [NUM_ENG];
  logic [NUM_ENG-1:0] w_ready;
  logic [C_RRW-1:0] w_gnt_idx;
  logic [C_RRW-1:0] w_rr_next;
  logic             w_found;
  logic [LIT_W-1:0] w_lit;
  logic [LIT_W-1:0] w_neg;
  logic             w_lit_nz;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_dup;
  logic             w_conf_set;
  logic [DEPTH-1:0] w_ent_valid;
  logic [DEPTH-1:0] w_neg_hit;
`ifdef UC_DEDUP_EN
  logic [DEPTH-1:0] w_dup_hit;
`endif

  // Scan order starts at the round-robin pointer and wraps mod NUM_ENG.
  for (genvar k = 0; k < NUM_ENG; k++) begin : g_order
    logic [C_RRW:0] w_sum;
    assign w_eng_lit[k] = eng_lit[k*LIT_W +: LIT_W];
    assign w_sum        = {1'b0, r_rr} + (C_RRW+1)'(k);
    assign w_order[k]   = (w_sum >= (C_RRW+1)'(NUM_ENG)) ?
                          C_RRW'(w_sum - (C_RRW+1)'(NUM_ENG)) : C_RRW'(w_sum);
  end

  always_comb begin
    w_ready   = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    if (rst_n && !w_full && !r_conflict) begin
      for (int k = 0; k < NUM_ENG; k++) begin
        if (!w_found && eng_valid[w_order[k]]) begin
          w_found             = 1'b1;
          w_gnt_idx           = w_order[k];
          w_ready[w_order[k]] = 1'b1;
        end
      end
    end
  end

  assign w_lit     = w_eng_lit[w_gnt_idx];
  assign w_neg     = -w_lit;
  assign w_lit_nz  = |w_lit;
  assign w_full    = (r_count == C_CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_rr_next = (w_gnt_idx == C_RRW'(NUM_ENG-1)) ? '0 : w_gnt_idx + 1'b1;

  // An entry is live when its distance from the read pointer is below count.
  for (genvar j = 0; j < DEPTH; j++) begin : g_ent
    logic [C_AW-1:0] w_off;
    assign w_off          = C_AW'(j) - r_rptr;
    assign w_ent_valid[j] = (C_CW'(w_off) < r_count);
    assign w_neg_hit[j]   = w_ent_valid[j] && (r_mem[j] == w_neg);
`ifdef UC_DEDUP_EN
    assign w_dup_hit[j]   = w_ent_valid[j] && (r_mem[j] == w_lit);
`endif
  end

`ifdef UC_DEDUP_EN
  assign w_dup = |w_dup_hit;
`else
  assign w_dup = 1'b0;
`endif

  assign w_conf_set = w_found && w_lit_nz && (|w_neg_hit);
  assign w_push     = w_found && w_lit_nz && !w_dup;
  assign w_pop      = rst_n && gst2ucarb_pop && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_lit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_rr       <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_found) begin
        r_rr <= w_rr_next;
      end
      if (w_conf_set) begin
        r_conflict <= 1'b1;
      end else if (conflict_clr) begin
        r_conflict <= 1'b0;
      end
    end
  end

  assign eng_ready       = w_ready;
  assign ucarb2gst_lit   = w_empty ? '0 : r_mem[r_rptr];
  assign ucarb2gst_empty = w_empty;
  assign full            = w_full;
  assign count           = r_count;
  assign conflict        = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_uc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uc_arbiter
// Description : Directed and randomized bench for uc_arbiter against a
//               queue-based model of the arbiter and FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uc_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int D = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] eng_lit = '0;
  logic [N-1:0]   eng_valid = '0;
  logic [N-1:0]   eng_ready;
  logic [W-1:0]   ucarb2gst_lit;
  logic           ucarb2gst_empty;
  logic           gst2ucarb_pop = 1'b0;
  logic           full;
  logic [4:0]     count;
  logic           conflict;
  logic           conflict_clr = 1'b0;

  uc_arbiter #(.NUM_ENG(N), .LIT_W(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .eng_lit(eng_lit), .eng_valid(eng_valid),
    .eng_ready(eng_ready), .ucarb2gst_lit(ucarb2gst_lit),
    .ucarb2gst_empty(ucarb2gst_empty), .gst2ucarb_pop(gst2ucarb_pop),
    .full(full), .count(count), .conflict(conflict), .conflict_clr(conflict_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] mq[$];
  int           mrr = 0;
  bit           mconf = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lit(input int e, input logic [W-1:0] v);
    eng_lit[e*W +: W] = v;
  endtask

  // Model: outputs derived from the queue, then advanced to the next edge.
  logic [N-1:0] er;
  logic [W-1:0] el, ml, mneg;
  int           g, e;
  bit           setc, dup, drop;
  always @(negedge clk) begin
    er = '0;
    g  = 0;
    if (rst_n && mq.size() < D && !mconf) begin
      for (int k = 0; k < N; k++) begin
        e = (mrr + k) % N;
        if (er == '0 && eng_valid[e]) begin
          er[e] = 1'b1;
          g = e;
        end
      end
    end
    el = (mq.size() > 0) ? mq[0] : '0;
    if (chk_en) begin
      chk("eng_ready", 32'(er), 32'(eng_ready));
      chk("head_lit", 32'(ucarb2gst_lit), 32'(el));
      chk("empty", 32'(ucarb2gst_empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == D));
      chk("count", 32'(count), 32'(mq.size()));
      chk("conflict", 32'(conflict), 32'(mconf));
    end
    if (!rst_n) begin
      mq.delete();
      mrr = 0;
      mconf = 1'b0;
    end else begin
      setc = 1'b0;
      dup  = 1'b0;
      ml   = '0;
      if (er != '0) begin
        ml   = eng_lit[g*W +: W];
        mneg = -ml;
        if (ml != '0) begin
          foreach (mq[i]) begin
            if (mq[i] == mneg) setc = 1'b1;
            if (mq[i] == ml) dup = 1'b1;
          end
        end
        mrr = (g + 1) % N;
      end
`ifdef UC_DEDUP_EN
      drop = dup;
`else
      drop = 1'b0;
`endif
      if (gst2ucarb_pop && mq.size() > 0) void'(mq.pop_front());
      if (er != '0 && ml != '0 && !drop) mq.push_back(ml);
      if (setc) mconf = 1'b1;
      else if (conflict_clr) mconf = 1'b0;
    end
  end

  logic [W-1:0] exp_pop [4];

  initial begin
    exp_pop = '{8'd3, 8'd5, 8'hF9, 8'd9};
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    chk("idle_empty", 32'(ucarb2gst_empty), 32'd1);
    chk("idle_lit", 32'(ucarb2gst_lit), 32'd0);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_conflict", 32'(conflict), 32'd0);
    chk("idle_ready", 32'(eng_ready), 32'd0);

    // Four engines, round-robin grants then in-order drain.
    set_lit(0, 8'd3); set_lit(1, 8'd5); set_lit(2, 8'hF9); set_lit(3, 8'd9);
    eng_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_grant", 32'(eng_ready), 32'(1 << k));
      tick();
    end
    eng_valid = '0;
    gst2ucarb_pop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("pop_order", 32'(ucarb2gst_lit), 32'(exp_pop[k]));
      tick();
    end
    gst2ucarb_pop = 1'b0;
    #1;
    chk("drained_empty", 32'(ucarb2gst_empty), 32'd1);

    // Fill to capacity; a same-cycle pop must not open a slot.
    eng_valid = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      set_lit(0, 8'(k + 1));
      tick();
    end
    set_lit(0, 8'd20);
    gst2ucarb_pop = 1'b1;
    #1;
    chk("full_flag", 32'(full), 32'd1);
    chk("full_ready", 32'(eng_ready), 32'd0);
    chk("full_count", 32'(count), 32'd16);
    tick();
    gst2ucarb_pop = 1'b0;
    #1;
    chk("after_pop_count", 32'(count), 32'd15);
    chk("after_pop_ready", 32'(eng_ready), 32'd1);
    tick();
    eng_valid = '0;
    #1;
    chk("refill_count", 32'(count), 32'd16);
    gst2ucarb_pop = 1'b1;
    repeat (16) tick();
    gst2ucarb_pop = 1'b0;
    #1;
    chk("refill_drained", 32'(ucarb2gst_empty), 32'd1);

    // Conflict between 4 and -4.
    eng_valid = 4'b0010;
    set_lit(1, 8'd4);
    tick();
    set_lit(1, 8'hFC);
    tick();
    #1;
    chk("conf_set", 32'(conflict), 32'd1);
    chk("conf_count", 32'(count), 32'd2);
    chk("conf_ready", 32'(eng_ready), 32'd0);
    eng_valid = '0;
    conflict_clr = 1'b1;
    tick();
    conflict_clr = 1'b0;
    #1;
    chk("conf_clr", 32'(conflict), 32'd0);
    gst2ucarb_pop = 1'b1;
    repeat (2) tick();
    gst2ucarb_pop = 1'b0;

    // Zero literal from engine 2 moves rr to 3 without a push.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    eng_valid = 4'b0100;
    set_lit(2, 8'd0);
    #1;
    chk("zero_ready", 32'(eng_ready), 32'h4);
    tick();
    eng_valid = '0;
    #1;
    chk("zero_count", 32'(count), 32'd0);
    set_lit(0, 8'd1); set_lit(1, 8'd2); set_lit(2, 8'd3); set_lit(3, 8'd4);
    eng_valid = 4'hF;
    #1;
    chk("zero_rr", 32'(eng_ready), 32'h8);
    eng_valid = '0;
    gst2ucarb_pop = 1'b1;
    tick();
    gst2ucarb_pop = 1'b0;
    #1;
    chk("pop_empty_count", 32'(count), 32'd0);
    chk("pop_empty_flag", 32'(ucarb2gst_empty), 32'd1);

    // Duplicate literal handling.
    eng_valid = 4'b0001;
    set_lit(0, 8'd6);
    repeat (2) tick();
    eng_valid = '0;
    #1;
`ifdef UC_DEDUP_EN
    chk("dup_count", 32'(count), 32'd1);
    chk("dup_head", 32'(ucarb2gst_lit), 32'd6);
    gst2ucarb_pop = 1'b1;
    tick();
`else
    chk("dup_count", 32'(count), 32'd2);
    gst2ucarb_pop = 1'b1;
    chk("dup_head0", 32'(ucarb2gst_lit), 32'd6);
    tick();
    #1;
    chk("dup_head1", 32'(ucarb2gst_lit), 32'd6);
    tick();
`endif
    gst2ucarb_pop = 1'b0;
    #1;
    chk("dup_drained", 32'(ucarb2gst_empty), 32'd1);

    // Reset mid-operation discards buffered literals.
    eng_valid = 4'b0001;
    set_lit(0, 8'd11);
    repeat (2) tick();
    eng_valid = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(ucarb2gst_empty), 32'd1);

    // Randomized traffic; the model checks every cycle.
    for (int c = 0; c < 2000; c++) begin
      eng_valid = 4'($urandom);
      for (int k = 0; k < N; k++) set_lit(k, 8'($urandom_range(0, 14)) - 8'd7);
      gst2ucarb_pop = ($urandom_range(0, 9) < 4);
      conflict_clr  = ($urandom_range(0, 9) == 0);
      rst_n         = ($urandom_range(0, 299) != 0);
      tick();
    end
    eng_valid = '0;
    gst2ucarb_pop = 1'b0;
    conflict_clr = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
